video_sync_normalizer: RTL and testbench

Upstream conditioning stage that sits between a core's raw video output and the MiST video pipeline (scandoubler/OSD/cofi/YPbPr chain).
- Detects the polarity of HSync and VSync by measuring their phase lengths.
- Re-emits both syncs as active-low, forces RGB to zero during blanking, and registers everything on the pixel enable.
- Downstream stages therefore see clean, uniformly polarised, blank-aligned video.

---
 rtl/video_pkg.sv | 13 +
 rtl/video_sync_normalizer_if.sv | 36 +++
 rtl/sync_polarity_detect.sv | 83 ++++++++
 rtl/video_sync_normalizer.sv | 155 +++++++++++++++
 tb/tb_video_sync_normalizer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video sync normalizer.
package video_pkg;

  typedef enum logic [1:0] {
    StUnlocked,
    StCounting,
    StLocked
  } lock_state_e;

  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/video_sync_normalizer_if.sv
// Raw core video in / normalised video out bundle.
// With SYNC_NORM_MEASURE_EN defined, also carries the active-area measurements.
interface video_sync_normalizer_if #(
  parameter int unsigned COLOR_DEPTH = 6
`ifdef SYNC_NORM_MEASURE_EN
  , parameter int unsigned HCNT_WIDTH = 12,
  parameter int unsigned VCNT_WIDTH = 10
`endif
);
  logic [COLOR_DEPTH-1:0] R, G, B;
  logic                   HSync, VSync, HBlank, VBlank;
  logic [COLOR_DEPTH-1:0] R_out, G_out, B_out;
  logic                   HSync_out, VSync_out, hs_pol, vs_pol, locked;
`ifdef SYNC_NORM_MEASURE_EN
  logic [HCNT_WIDTH-1:0]  h_active;
  logic [VCNT_WIDTH-1:0]  v_active;

  modport master (
    output R, G, B, HSync, VSync, HBlank, VBlank,
    input  R_out, G_out, B_out, HSync_out, VSync_out, hs_pol, vs_pol, locked, h_active, v_active
  );
  modport slave (
    input  R, G, B, HSync, VSync, HBlank, VBlank,
    output R_out, G_out, B_out, HSync_out, VSync_out, hs_pol, vs_pol, locked, h_active, v_active
  );
`else
  modport master (
    output R, G, B, HSync, VSync, HBlank, VBlank,
    input  R_out, G_out, B_out, HSync_out, VSync_out, hs_pol, vs_pol, locked
  );
  modport slave (
    input  R, G, B, HSync, VSync, HBlank, VBlank,
    output R_out, G_out, B_out, HSync_out, VSync_out, hs_pol, vs_pol, locked
  );
`endif
endinterface

// File: rtl/sync_polarity_detect.sv
// Measures high/low phase lengths of a sync on each tick and infers its polarity:
// the shorter phase is the active one.
module sync_polarity_detect
  import video_pkg::*;
#(
  parameter int unsigned CntWidth = 12
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tick,
  input  logic sync,
  output logic pol,
  output logic resolved
);

  localparam logic [CntWidth-1:0] CntMax = '1;

  logic                sync_q;
  logic                pol_q, pol_d;
  logic                hi_ok_q, hi_ok_d, lo_ok_q, lo_ok_d;
  logic                len_ok;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] hi_len_q, hi_len_d, lo_len_q, lo_len_d;

  // Zero only occurs for the phase "ending" on the very first tick after reset.
  assign len_ok = (cnt_q != '0) && (cnt_q != CntMax);

  always_comb begin
    cnt_d    = cnt_q;
    hi_len_d = hi_len_q;
    lo_len_d = lo_len_q;
    hi_ok_d  = hi_ok_q;
    lo_ok_d  = lo_ok_q;
    pol_d    = pol_q;
    if (tick) begin
      if (sync != sync_q) begin
        cnt_d = CntWidth'(1);
        if (sync_q) begin
          hi_len_d = cnt_q;
          hi_ok_d  = len_ok;
        end else begin
          lo_len_d = cnt_q;
          lo_ok_d  = len_ok;
        end
        if (hi_ok_d && lo_ok_d) begin
          if (hi_len_d < lo_len_d) begin
            pol_d = POL_ACTIVE_HIGH;
          end else if (lo_len_d < hi_len_d) begin
            pol_d = POL_ACTIVE_LOW;
          end
        end
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      hi_ok_q  <= 1'b0;
      lo_ok_q  <= 1'b0;
      pol_q    <= POL_ACTIVE_LOW;
    end else begin
      cnt_q    <= cnt_d;
      hi_len_q <= hi_len_d;
      lo_len_q <= lo_len_d;
      hi_ok_q  <= hi_ok_d;
      lo_ok_q  <= lo_ok_d;
      pol_q    <= pol_d;
      if (tick) begin
        sync_q <= sync;
      end
    end
  end

  assign pol      = pol_q;
  assign resolved = hi_ok_q & lo_ok_q;

endmodule

// File: rtl/video_sync_normalizer.sv
// Normalises raw core syncs to active-low, blanks colour, and tracks polarity lock.
// Optional SYNC_NORM_MEASURE_EN adds h_active/v_active measurement outputs.
module video_sync_normalizer
  import video_pkg::*;
#(
  parameter int unsigned COLOR_DEPTH = 6,
  parameter int unsigned HCNT_WIDTH  = 12,
  parameter int unsigned VCNT_WIDTH  = 10,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                    clk_sys,
  input logic                    reset_n,
  input logic                    ce_pix,
  video_sync_normalizer_if.slave vid
);

  localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);

  logic                   hs_pol, vs_pol, hs_res, vs_res;
  logic                   hs_pol_q, vs_pol_q;
  logic                   hs_out_q, hs_out_d, vs_out_q, vs_out_d;
  logic                   line_tick, frame_evt, pol_chg, blank;
  logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
  lock_state_e            state_q, state_d;
  logic [3:0]             lock_cnt_q, lock_cnt_d;

  assign blank     = vid.HBlank | vid.VBlank;
  assign hs_out_d  = vid.HSync ^ hs_pol;
  assign vs_out_d  = vid.VSync ^ vs_pol;
  assign line_tick = ce_pix & hs_out_q & ~hs_out_d;
  assign frame_evt = ce_pix & vs_out_q & ~vs_out_d;
  assign pol_chg   = (hs_pol != hs_pol_q) | (vs_pol != vs_pol_q);

  sync_polarity_detect #(
    .CntWidth (HCNT_WIDTH)
  ) u_h_detect (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (ce_pix),
    .sync     (vid.HSync),
    .pol      (hs_pol),
    .resolved (hs_res)
  );

  // Vertical phases are measured in lines, one tick per normalised hsync leading edge.
  sync_polarity_detect #(
    .CntWidth (VCNT_WIDTH)
  ) u_v_detect (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tick     (line_tick),
    .sync     (vid.VSync),
    .pol      (vs_pol),
    .resolved (vs_res)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
    end else if (ce_pix) begin
      r_q      <= blank ? '0 : vid.R;
      g_q      <= blank ? '0 : vid.G;
      b_q      <= blank ? '0 : vid.B;
      hs_out_q <= hs_out_d;
      vs_out_q <= vs_out_d;
    end
  end

  // A polarity change outranks a coincident frame event.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (pol_chg) begin
      state_d    = StCounting;
      lock_cnt_d = '0;
    end else if (frame_evt) begin
      case (state_q)
        StUnlocked: begin
          if (hs_res && vs_res) begin
            state_d    = StCounting;
            lock_cnt_d = 4'd1;
          end
        end
        StCounting: lock_cnt_d = lock_cnt_q + 4'd1;
        default:    ;
      endcase
      if (state_d == StCounting && lock_cnt_d >= LockFrames) begin
        state_d = StLocked;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StUnlocked;
      lock_cnt_q <= '0;
      hs_pol_q   <= POL_ACTIVE_LOW;
      vs_pol_q   <= POL_ACTIVE_LOW;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hs_pol_q   <= hs_pol;
      vs_pol_q   <= vs_pol;
    end
  end

  assign vid.R_out     = r_q;
  assign vid.G_out     = g_q;
  assign vid.B_out     = b_q;
  assign vid.HSync_out = hs_out_q;
  assign vid.VSync_out = vs_out_q;
  assign vid.hs_pol    = hs_pol;
  assign vid.vs_pol    = vs_pol;
  assign vid.locked    = (state_q == StLocked);

`ifdef SYNC_NORM_MEASURE_EN
  logic                  hblank_q, vblank_q;
  logic [HCNT_WIDTH-1:0] h_cnt_q, h_act_q;
  logic [VCNT_WIDTH-1:0] v_cnt_q, v_act_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      h_cnt_q  <= '0;
      h_act_q  <= '0;
      v_cnt_q  <= '0;
      v_act_q  <= '0;
    end else if (ce_pix) begin
      hblank_q <= vid.HBlank;
      vblank_q <= vid.VBlank;
      if (vid.HBlank && !hblank_q) begin
        h_act_q <= h_cnt_q;
        h_cnt_q <= '0;
      end else if (!vid.HBlank && h_cnt_q != '1) begin
        h_cnt_q <= h_cnt_q + HCNT_WIDTH'(1);
      end
      if (vid.VBlank && !vblank_q) begin
        v_act_q <= v_cnt_q;
        v_cnt_q <= '0;
      end else if (line_tick && !vid.VBlank && v_cnt_q != '1) begin
        v_cnt_q <= v_cnt_q + VCNT_WIDTH'(1);
      end
    end
  end

  assign vid.h_active = h_act_q;
  assign vid.v_active = v_act_q;
`endif

endmodule

// File: tb/tb_video_sync_normalizer.sv
// Self-checking bench for video_sync_normalizer: vector table, directed corner sequences,
// and randomized video timing checked every cycle against a phase-length reference model.
module tb_video_sync_normalizer;
  localparam int LockFrames = 2;
  localparam int HSat = 4095;
  localparam int VSat = 1023;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_pix = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  video_sync_normalizer_if #(.COLOR_DEPTH(6)) vid ();

  video_sync_normalizer #(
    .COLOR_DEPTH (6),
    .HCNT_WIDTH  (12),
    .VCNT_WIDTH  (10),
    .LOCK_FRAMES (LockFrames)
  ) u_dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Index 0 = horizontal, 1 = vertical. Phase lengths are plain run counts.
  int       m_run[2], m_hi[2], m_lo[2];
  logic     m_lvl[2], m_pol[2], m_seen[2];
  logic [5:0] m_r, m_g, m_b;
  logic     m_hs_out, m_vs_out;
  logic     m_started, m_locked;
  int       m_count;

  function automatic bit len_ok(int len, int k);
    return len > 0 && len < ((k == 0) ? HSat : VSat);
  endfunction

  function automatic bit resolved(int k);
    return len_ok(m_hi[k], k) && len_ok(m_lo[k], k);
  endfunction

  function automatic void detect(int k, logic s);
    int len;
    if (s != m_lvl[k]) begin
      len = m_run[k];
      if (len > ((k == 0) ? HSat : VSat)) len = (k == 0) ? HSat : VSat;
      if (m_lvl[k]) m_hi[k] = len;
      else m_lo[k] = len;
      m_run[k] = 1;
      m_lvl[k] = s;
      if (resolved(k)) begin
        if (m_hi[k] < m_lo[k]) m_pol[k] = 1'b1;
        else if (m_lo[k] < m_hi[k]) m_pol[k] = 1'b0;
      end
    end else begin
      m_run[k] = m_run[k] + 1;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
      m_lvl[k] = 1'b0; m_pol[k] = 1'b0; m_seen[k] = 1'b0;
    end
    m_r = '0; m_g = '0; m_b = '0;
    m_hs_out = 1'b1; m_vs_out = 1'b1;
    m_started = 1'b0; m_locked = 1'b0; m_count = 0;
  endfunction

  function automatic void model_step();
    logic chg, frame, line, res, nh, nv;
    chg = (m_pol[0] != m_seen[0]) || (m_pol[1] != m_seen[1]);
    m_seen[0] = m_pol[0];
    m_seen[1] = m_pol[1];
    res = resolved(0) && resolved(1);
    frame = 1'b0;
    if (ce_pix) begin
      nh = vid.HSync ^ m_pol[0];
      nv = vid.VSync ^ m_pol[1];
      line = m_hs_out && !nh;
      frame = m_vs_out && !nv;
      m_hs_out = nh;
      m_vs_out = nv;
      if (vid.HBlank || vid.VBlank) begin
        m_r = '0; m_g = '0; m_b = '0;
      end else begin
        m_r = vid.R; m_g = vid.G; m_b = vid.B;
      end
      detect(0, vid.HSync);
      if (line) detect(1, vid.VSync);
    end
    if (chg) begin
      m_started = 1'b1; m_count = 0; m_locked = 1'b0;
    end else if (frame) begin
      if (!m_started) begin
        if (res) begin
          m_started = 1'b1; m_count = 1;
        end
      end else if (!m_locked) begin
        m_count = m_count + 1;
      end
      if (m_started && !m_locked && m_count >= LockFrames) m_locked = 1'b1;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- checking / driving ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("r_out", 32'(vid.R_out), 32'(m_r));
    chk("g_out", 32'(vid.G_out), 32'(m_g));
    chk("b_out", 32'(vid.B_out), 32'(m_b));
    chk("hsync_out", 32'(vid.HSync_out), 32'(m_hs_out));
    chk("vsync_out", 32'(vid.VSync_out), 32'(m_vs_out));
    chk("hs_pol", 32'(vid.hs_pol), 32'(m_pol[0]));
    chk("vs_pol", 32'(vid.vs_pol), 32'(m_pol[1]));
    chk("locked", 32'(vid.locked), 32'(m_locked));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, 32'({vid.R_out, vid.G_out, vid.B_out}), 32'h0);
    chk({tag, "_hs"}, 32'(vid.HSync_out), 32'h1);
    chk({tag, "_vs"}, 32'(vid.VSync_out), 32'h1);
    chk({tag, "_hpol"}, 32'(vid.hs_pol), 32'h0);
    chk({tag, "_vpol"}, 32'(vid.vs_pol), 32'h0);
    chk({tag, "_lock"}, 32'(vid.locked), 32'h0);
  endtask

  bit   watch_flip = 0, flip_seen = 0, flip_checked = 0;
  logic last_hs_pol = 1'b0;

  // One clock: apply inputs, let the edge pass, compare on the falling edge.
  task automatic drive(input logic ce, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input logic hs, input logic vs,
                       input logic hb, input logic vb);
    ce_pix = ce; vid.R = r; vid.G = g; vid.B = b;
    vid.HSync = hs; vid.VSync = vs; vid.HBlank = hb; vid.VBlank = vb;
    @(posedge clk);
    @(negedge clk);
    chk_model();
    if (watch_flip) begin
      if (flip_seen && !flip_checked) begin
        chk("unlock_after_flip", 32'(vid.locked), 32'h0);
        flip_checked = 1;
      end
      if (vid.hs_pol !== last_hs_pol) flip_seen = 1;
    end
    last_hs_pol = vid.hs_pol;
  endtask

  task automatic run_frames(input int htot, input int hsw, input logic hp, input int vtot,
                            input int vsw, input logic vp, input int frames, input int ce_pct);
    logic hs, vs, hb, vb;
    for (int f = 0; f < frames; f++) begin
      for (int y = 0; y < vtot; y++) begin
        for (int x = 0; x < htot; x++) begin
          hs = (x < hsw) ? hp : ~hp;
          vs = (y < vsw) ? vp : ~vp;
          hb = (x < hsw + 2) || (x >= htot - 2);
          vb = (y < vsw + 1);
          while ($urandom_range(99) >= ce_pct) begin
            drive(1'b0, 6'($urandom), 6'($urandom), 6'($urandom), hs, vs, hb, vb);
          end
          drive(1'b1, 6'($urandom), 6'($urandom), 6'($urandom), hs, vs, hb, vb);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       ce;
    logic       hb;
    logic       vb;
    logic [5:0] rgb;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   low_cnt;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 6'h3F, 6'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 6'h3F, 6'h3F};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'h00, 6'h3F};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 6'h15, 6'h3F};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 6'h15, 6'h15};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 6'h2A, 6'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 6'h2A, 6'h00};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 6'h2A, 6'h2A};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 6'h3F, 6'h00};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 6'h01, 6'h01};

    vid.R = '0; vid.G = '0; vid.B = '0;
    vid.HSync = 1'b1; vid.VSync = 1'b1; vid.HBlank = 1'b0; vid.VBlank = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // Colour blanking, latency and hold across ce_pix gaps.
    foreach (vecs[i]) begin
      drive(vecs[i].ce, vecs[i].rgb, vecs[i].rgb, vecs[i].rgb, 1'b1, 1'b1, vecs[i].hb,
            vecs[i].vb);
      chk($sformatf("vec%0d_r", i), 32'(vid.R_out), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_g", i), 32'(vid.G_out), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_b", i), 32'(vid.B_out), 32'(vecs[i].exp));
    end

    // Active-high H, 96 high / 704 low; polarity flips on the low->high edge.
    do_reset();
    for (int x = 0; x < 800; x++) drive(1'b1, 6'h3F, 6'h3F, 6'h3F, x < 96, 1'b1, 1'b0, 1'b0);
    chk("ahigh_pol_before", 32'(vid.hs_pol), 32'h0);
    drive(1'b1, 6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ahigh_pol_after", 32'(vid.hs_pol), 32'h1);
    for (int x = 1; x < 800; x++) drive(1'b1, 6'h3F, 6'h3F, 6'h3F, x < 96, 1'b1, 1'b0, 1'b0);
    low_cnt = 0;
    for (int x = 0; x < 800; x++) begin
      drive(1'b1, 6'h3F, 6'h3F, 6'h3F, x < 96, 1'b1, 1'b0, 1'b0);
      if (x == 0) chk("ahigh_out_first", 32'(vid.HSync_out), 32'h0);
      if (x == 96) chk("ahigh_out_end", 32'(vid.HSync_out), 32'h1);
      if (vid.HSync_out == 1'b0) low_cnt++;
    end
    chk("ahigh_low_width", 32'(low_cnt), 32'd96);

    // Active-low H and V lock, then a mid-run H polarity flip.
    do_reset();
    run_frames(80, 10, 1'b0, 12, 2, 1'b0, 5, 100);
    chk("alow_hpol", 32'(vid.hs_pol), 32'h0);
    chk("alow_vpol", 32'(vid.vs_pol), 32'h0);
    chk("alow_locked", 32'(vid.locked), 32'h1);
    watch_flip = 1;
    last_hs_pol = vid.hs_pol;
    run_frames(80, 10, 1'b1, 12, 2, 1'b0, 4, 100);
    watch_flip = 0;
    chk("flip_detected", 32'(flip_checked), 32'h1);
    chk("flip_hpol", 32'(vid.hs_pol), 32'h1);
    chk("flip_relocked", 32'(vid.locked), 32'h1);

    // HSync stuck high: counter saturates, nothing resolves.
    do_reset();
    for (int i = 0; i < 5000; i++) drive(1'b1, 6'h11, 6'h22, 6'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stuck_cnt_sat", 32'(u_dut.u_h_detect.cnt_q), 32'd4095);
    chk("stuck_hpol", 32'(vid.hs_pol), 32'h0);
    chk("stuck_locked", 32'(vid.locked), 32'h0);

    // Asynchronous reset mid-line, then re-detection from scratch.
    do_reset();
    run_frames(80, 10, 1'b1, 2, 0, 1'b0, 1, 100);
    chk("prerst_hpol", 32'(vid.hs_pol), 32'h1);
    for (int x = 0; x < 30; x++) drive(1'b1, 6'h2D, 6'h1B, 6'h36, x < 10, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 6'h2D, 6'h1B, 6'h36, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("postrst_hpol_clear", 32'(vid.hs_pol), 32'h0);
    run_frames(80, 10, 1'b1, 3, 0, 1'b0, 1, 100);
    chk("postrst_hpol", 32'(vid.hs_pol), 32'h1);

    // Randomized timings, polarities and ce_pix duty against the model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      run_frames($urandom_range(60, 30), $urandom_range(8, 3), 1'($urandom),
                 $urandom_range(14, 8), $urandom_range(3, 1), 1'($urandom),
                 5, $urandom_range(100, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
